// File: rtl/easyaxi_rd_arb.sv
// easyaxi_rd_arb: N-master to 1-slave AXI read-channel interconnect.
// Round-robin AR arbitration with a grant lock held across slave backpressure,
// R routing by the upper rid bits, and per-master outstanding-burst limits.
module easyaxi_rd_arb #(
   parameter  int unsigned MST_NUM = 4,
   parameter  int unsigned ID_W    = 4,
   parameter  int unsigned ADDR_W  = 32,
   parameter  int unsigned DATA_W  = 32,
   parameter  int unsigned LEN_W   = 8,
   parameter  int unsigned SIZE_W  = 3,
   parameter  int unsigned BURST_W = 2,
   parameter  int unsigned RESP_W  = 2,
   parameter  int unsigned MAX_OST = 2,
   localparam int unsigned IDX_W   = $clog2(MST_NUM),
   localparam int unsigned CNT_W   = $clog2(MAX_OST + 1)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   // master side
   input  logic [MST_NUM-1:0]           mst_arvalid,
   output logic [MST_NUM-1:0]           mst_arready,
   input  logic [MST_NUM*ID_W-1:0]      mst_arid,
   input  logic [MST_NUM*ADDR_W-1:0]    mst_araddr,
   input  logic [MST_NUM*LEN_W-1:0]     mst_arlen,
   input  logic [MST_NUM*SIZE_W-1:0]    mst_arsize,
   input  logic [MST_NUM*BURST_W-1:0]   mst_arburst,
   output logic [MST_NUM-1:0]           mst_rvalid,
   input  logic [MST_NUM-1:0]           mst_rready,
   output logic [MST_NUM*ID_W-1:0]      mst_rid,
   output logic [MST_NUM*DATA_W-1:0]    mst_rdata,
   output logic [MST_NUM*RESP_W-1:0]    mst_rresp,
   output logic [MST_NUM-1:0]           mst_rlast,
   // slave side
   output logic                         slv_arvalid,
   input  logic                         slv_arready,
   output logic [IDX_W+ID_W-1:0]        slv_arid,
   output logic [ADDR_W-1:0]            slv_araddr,
   output logic [LEN_W-1:0]             slv_arlen,
   output logic [SIZE_W-1:0]            slv_arsize,
   output logic [BURST_W-1:0]           slv_arburst,
   input  logic                         slv_rvalid,
   output logic                         slv_rready,
   input  logic [IDX_W+ID_W-1:0]        slv_rid,
   input  logic [DATA_W-1:0]            slv_rdata,
   input  logic [RESP_W-1:0]            slv_rresp,
   input  logic                         slv_rlast
);

   typedef enum logic {ST_OPEN, ST_LOCK} lock_st_t;

   lock_st_t             lock_st_q;
   logic [IDX_W-1:0]     lock_idx_q;
   logic [IDX_W-1:0]     rr_ptr_q;
   logic [CNT_W-1:0]     ost_cnt_q [MST_NUM];

   logic [MST_NUM-1:0]   req;
   logic [IDX_W-1:0]     cand;
   logic [IDX_W-1:0]     win_idx;
   logic                 win_found;
   logic [IDX_W-1:0]     grant_idx;
   logic [IDX_W-1:0]     grant_nxt;
   logic                 ar_hs;
   logic [IDX_W-1:0]     rsel;
   logic                 rsel_ok;
   logic                 r_last_hs;
   logic [MST_NUM-1:0]   ost_inc;
   logic [MST_NUM-1:0]   ost_dec;

   // a master may request only while below its outstanding-burst limit
   always_comb begin
      req = '0;
      for (int unsigned i = 0; i < MST_NUM; i++) begin
         req[i] = mst_arvalid[i] & (ost_cnt_q[i] < CNT_W'(MAX_OST));
      end
   end

   // round-robin search starting at rr_ptr, wrapping at MST_NUM
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int unsigned k = 0; k < MST_NUM; k++) begin
         cand = IDX_W'((32'(rr_ptr_q) + k) % MST_NUM);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   // a locked grant overrides arbitration until its handshake completes
   always_comb begin
      grant_idx   = (lock_st_q == ST_LOCK) ? lock_idx_q : win_idx;
      slv_arvalid = (lock_st_q == ST_LOCK) ? 1'b1 : win_found;
      ar_hs       = slv_arvalid & slv_arready;
      grant_nxt   = (32'(grant_idx) == MST_NUM - 1) ? '0 : grant_idx + 1'b1;
      mst_arready = '0;
      if (slv_arvalid) mst_arready[grant_idx] = slv_arready;
   end

   // granted master's AR payload, id tagged with its index
   assign slv_arid    = {grant_idx, mst_arid[grant_idx*ID_W +: ID_W]};
   assign slv_araddr  = mst_araddr[grant_idx*ADDR_W +: ADDR_W];
   assign slv_arlen   = mst_arlen[grant_idx*LEN_W +: LEN_W];
   assign slv_arsize  = mst_arsize[grant_idx*SIZE_W +: SIZE_W];
   assign slv_arburst = mst_arburst[grant_idx*BURST_W +: BURST_W];

   // lock and round-robin pointer state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lock_st_q  <= ST_OPEN;
         lock_idx_q <= '0;
         rr_ptr_q   <= '0;
      end else if (ar_hs) begin
         lock_st_q  <= ST_OPEN;
         rr_ptr_q   <= grant_nxt;
      end else if (slv_arvalid && (lock_st_q == ST_OPEN)) begin
         lock_st_q  <= ST_LOCK;
         lock_idx_q <= win_idx;
      end
   end

   // R routing by the index bits of rid; unknown indices are drained
   always_comb begin
      rsel       = slv_rid[ID_W +: IDX_W];
      rsel_ok    = (32'(rsel) < MST_NUM);
      mst_rvalid = '0;
      slv_rready = 1'b1;
      if (rsel_ok) begin
         mst_rvalid[rsel] = slv_rvalid;
         slv_rready       = mst_rready[rsel];
      end
      r_last_hs  = slv_rvalid & slv_rready & slv_rlast & rsel_ok;
   end

   // R payload is broadcast; only the selected master sees rvalid
   assign mst_rid   = {MST_NUM{slv_rid[ID_W-1:0]}};
   assign mst_rdata = {MST_NUM{slv_rdata}};
   assign mst_rresp = {MST_NUM{slv_rresp}};
   assign mst_rlast = {MST_NUM{slv_rlast}};

   // per-master counter events
   always_comb begin
      ost_inc = '0;
      ost_dec = '0;
      if (ar_hs)     ost_inc[grant_idx] = 1'b1;
      if (r_last_hs) ost_dec[rsel]      = 1'b1;
   end

   // outstanding-burst counters; simultaneous inc/dec cancel, decrement saturates at 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < MST_NUM; i++) ost_cnt_q[i] <= '0;
      end else begin
         for (int unsigned i = 0; i < MST_NUM; i++) begin
            if (ost_inc[i] && !ost_dec[i]) begin
               ost_cnt_q[i] <= ost_cnt_q[i] + CNT_W'(1);
            end else if (ost_dec[i] && !ost_inc[i] && (ost_cnt_q[i] != '0)) begin
               ost_cnt_q[i] <= ost_cnt_q[i] - CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_easyaxi_rd_arb.sv
// Testbench for easyaxi_rd_arb: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the arbiter.
module tb_easyaxi_rd_arb;

   localparam int unsigned N  = 4;
   localparam int unsigned IW = 4;
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned LW = 8;
   localparam int unsigned SW = 3;
   localparam int unsigned BW = 2;
   localparam int unsigned RW = 2;
   localparam int unsigned MO = 2;
   localparam int unsigned XW = 2;

   logic clk, rst_n;
   logic [N-1:0]    mst_arvalid, mst_arready, mst_rvalid, mst_rready, mst_rlast;
   logic [N*IW-1:0] mst_arid, mst_rid;
   logic [N*AW-1:0] mst_araddr;
   logic [N*LW-1:0] mst_arlen;
   logic [N*SW-1:0] mst_arsize;
   logic [N*BW-1:0] mst_arburst;
   logic [N*DW-1:0] mst_rdata;
   logic [N*RW-1:0] mst_rresp;
   logic            slv_arvalid, slv_arready, slv_rvalid, slv_rready, slv_rlast;
   logic [XW+IW-1:0] slv_arid, slv_rid;
   logic [AW-1:0]   slv_araddr;
   logic [LW-1:0]   slv_arlen;
   logic [SW-1:0]   slv_arsize;
   logic [BW-1:0]   slv_arburst;
   logic [DW-1:0]   slv_rdata;
   logic [RW-1:0]   slv_rresp;

   easyaxi_rd_arb #(
      .MST_NUM(N), .ID_W(IW), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW),
      .SIZE_W(SW), .BURST_W(BW), .RESP_W(RW), .MAX_OST(MO)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .mst_arvalid(mst_arvalid), .mst_arready(mst_arready), .mst_arid(mst_arid),
      .mst_araddr(mst_araddr), .mst_arlen(mst_arlen), .mst_arsize(mst_arsize),
      .mst_arburst(mst_arburst), .mst_rvalid(mst_rvalid), .mst_rready(mst_rready),
      .mst_rid(mst_rid), .mst_rdata(mst_rdata), .mst_rresp(mst_rresp), .mst_rlast(mst_rlast),
      .slv_arvalid(slv_arvalid), .slv_arready(slv_arready), .slv_arid(slv_arid),
      .slv_araddr(slv_araddr), .slv_arlen(slv_arlen), .slv_arsize(slv_arsize),
      .slv_arburst(slv_arburst), .slv_rvalid(slv_rvalid), .slv_rready(slv_rready),
      .slv_rid(slv_rid), .slv_rdata(slv_rdata), .slv_rresp(slv_rresp), .slv_rlast(slv_rlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int m_rr, m_lock, m_lidx;
   int m_ost [N];

   // DUT outputs sampled in the last step
   logic [N-1:0]     s_arready, s_rvalid;
   logic             s_arvalid, s_rready;
   logic [XW+IW-1:0] s_arid;
   logic [AW-1:0]    s_araddr;
   logic [LW-1:0]    s_arlen;
   logic [N*IW-1:0]  s_mrid;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   // one clock: compare outputs against the model, then advance the model at the edge
   task automatic step();
      int gnt, sel;
      bit av, any, sel_ok, exp_rr, ar_hs, r_fin;
      #1;
      if (!rst_n) begin
         m_rr = 0; m_lock = 0; m_lidx = 0;
         for (int i = 0; i < N; i++) m_ost[i] = 0;
      end
      gnt = 0; any = 0;
      if (m_lock != 0) begin
         gnt = m_lidx; av = 1;
      end else begin
         for (int k = 0; k < N; k++) begin
            int j;
            j = (m_rr + k) % N;
            if (!any && mst_arvalid[j] && (m_ost[j] < MO)) begin any = 1; gnt = j; end
         end
         av = any;
      end
      chk("slv_arvalid", 64'(slv_arvalid), 64'(av));
      chk("mst_arready", 64'(mst_arready), (av && slv_arready) ? (64'd1 << gnt) : 64'd0);
      if (av) begin
         chk("slv_arid",    64'(slv_arid),   (64'(gnt) << IW) | 64'(mst_arid[gnt*IW +: IW]));
         chk("slv_araddr",  64'(slv_araddr), 64'(mst_araddr[gnt*AW +: AW]));
         chk("slv_arlen",   64'(slv_arlen),  64'(mst_arlen[gnt*LW +: LW]));
         chk("slv_arsize",  64'(slv_arsize), 64'(mst_arsize[gnt*SW +: SW]));
         chk("slv_arburst", 64'(slv_arburst), 64'(mst_arburst[gnt*BW +: BW]));
      end
      sel    = int'(slv_rid >> IW);
      sel_ok = (sel < N);
      exp_rr = sel_ok ? mst_rready[sel] : 1'b1;
      chk("mst_rvalid", 64'(mst_rvalid), (slv_rvalid && sel_ok) ? (64'd1 << sel) : 64'd0);
      chk("slv_rready", 64'(slv_rready), 64'(exp_rr));
      if (slv_rvalid && sel_ok) begin
         chk("mst_rid",   64'(mst_rid[sel*IW +: IW]),   64'(slv_rid[IW-1:0]));
         chk("mst_rdata", 64'(mst_rdata[sel*DW +: DW]), 64'(slv_rdata));
         chk("mst_rresp", 64'(mst_rresp[sel*RW +: RW]), 64'(slv_rresp));
         chk("mst_rlast", 64'(mst_rlast[sel]),          64'(slv_rlast));
      end
      s_arready = mst_arready; s_rvalid = mst_rvalid; s_arvalid = slv_arvalid;
      s_rready = slv_rready; s_arid = slv_arid; s_araddr = slv_araddr;
      s_arlen = slv_arlen; s_mrid = mst_rid;
      ar_hs = av && slv_arready;
      r_fin = slv_rvalid && exp_rr && slv_rlast && sel_ok;
      @(posedge clk);
      if (rst_n) begin
         if (ar_hs && !(r_fin && sel == gnt)) m_ost[gnt]++;
         if (r_fin && !(ar_hs && sel == gnt) && m_ost[sel] > 0) m_ost[sel]--;
         if (ar_hs) begin
            m_lock = 0; m_rr = (gnt + 1) % N;
         end else if (av && m_lock == 0) begin
            m_lock = 1; m_lidx = gnt;
         end
      end
      @(negedge clk);
   endtask

   task automatic idle();
      mst_arvalid = '0; mst_arid = '0; mst_araddr = '0; mst_arlen = '0;
      mst_arsize = '0; mst_arburst = '0; mst_rready = '0;
      slv_arready = 1'b0; slv_rvalid = 1'b0; slv_rid = '0; slv_rdata = '0;
      slv_rresp = '0; slv_rlast = 1'b0;
   endtask

   task automatic set_ar(input int i, input logic [IW-1:0] id, input logic [AW-1:0] a);
      mst_arvalid[i] = 1'b1;
      mst_arid[i*IW +: IW] = id;
      mst_araddr[i*AW +: AW] = a;
      mst_arlen[i*LW +: LW] = LW'(i + 1);
      mst_arsize[i*SW +: SW] = 3'd2;
      mst_arburst[i*BW +: BW] = 2'd1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      step();
      rst_n = 1'b1;
   endtask

   // randomized-traffic agents
   typedef struct { logic [XW+IW-1:0] id; int len; } rq_t;
   rq_t             q[$];
   bit   [N-1:0]    pend;
   logic [IW-1:0]   p_id   [N];
   logic [AW-1:0]   p_addr [N];
   logic [LW-1:0]   p_len  [N];
   logic [SW-1:0]   p_size [N];
   logic [BW-1:0]   p_burst[N];
   bit              rv;
   int              beat;

   initial begin
      rst_n = 1'b0;
      idle();
      @(negedge clk);
      do_reset();
      chk("rst_arvalid", 64'(s_arvalid), 64'd0);

      // single master request and four-beat burst back
      idle(); set_ar(1, 4'h3, 32'h100); slv_arready = 1'b1;
      step();
      chk("tp1_arid", 64'(s_arid), 64'h13);
      chk("tp1_arready", 64'(s_arready), 64'b0010);
      idle(); mst_rready = '1;
      for (int b = 0; b < 4; b++) begin
         slv_rvalid = 1'b1; slv_rid = 6'h13; slv_rlast = (b == 3); slv_rdata = $urandom;
         step();
         chk("tp1_rvalid", 64'(s_rvalid), 64'b0010);
         chk("tp1_rid", 64'(s_mrid[7:4]), 64'h3);
      end
      idle(); set_ar(1, 4'h4, 32'h200); slv_arready = 1'b1;
      step(); chk("tp1_ost_a", 64'(s_arready), 64'b0010);
      step(); chk("tp1_ost_b", 64'(s_arready), 64'b0010);

      // round-robin over all four masters
      do_reset();
      idle(); for (int i = 0; i < N; i++) set_ar(i, IW'(i), AW'(32'h1000 * i));
      slv_arready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         chk("rr_gnt", 64'(s_arid[IW +: XW]), 64'(k % N));
      end

      // grant lock under slave backpressure
      do_reset();
      idle(); set_ar(0, 4'h1, 32'h10); slv_arready = 1'b1; step();
      idle(); set_ar(1, 4'h2, 32'h20); slv_arready = 1'b1; step();
      idle(); set_ar(0, 4'h5, 32'hA0); set_ar(2, 4'h7, 32'h2C0);
      for (int k = 0; k < 3; k++) begin
         step();
         chk("lock_gnt", 64'(s_arid[IW +: XW]), 64'd2);
         chk("lock_addr", 64'(s_araddr), 64'h2C0);
         chk("lock_m0_rdy", 64'(s_arready[0]), 64'd0);
      end
      slv_arready = 1'b1; step();
      chk("lock_hs", 64'(s_arready), 64'b0100);
      mst_arvalid[2] = 1'b0; step();
      chk("lock_next", 64'(s_arid[IW +: XW]), 64'd0);

      // outstanding limit
      do_reset();
      idle(); set_ar(0, 4'h1, 32'h10); slv_arready = 1'b1;
      step(); step();
      set_ar(1, 4'h2, 32'h20); step();
      chk("ost_m0_blk", 64'(s_arready), 64'b0010);
      mst_arvalid[1] = 1'b0;
      slv_rvalid = 1'b1; slv_rid = {2'd0, 4'h1}; slv_rlast = 1'b1; mst_rready[0] = 1'b1;
      step();
      chk("ost_none", 64'(s_arvalid), 64'd0);
      slv_rvalid = 1'b0; step();
      chk("ost_m0_again", 64'(s_arready), 64'b0001);

      // simultaneous AR and rlast for one master; held beat for a stalled master
      do_reset();
      idle(); set_ar(0, 4'h6, 32'h60); slv_arready = 1'b1; step();
      slv_rvalid = 1'b1; slv_rid = {2'd0, 4'h6}; slv_rlast = 1'b1; mst_rready = 4'b0001;
      step(); chk("sim_hs", 64'(s_arready), 64'b0001);
      slv_rvalid = 1'b0; step(); chk("sim_second", 64'(s_arready), 64'b0001);
      step(); chk("sim_full", 64'(s_arready), 64'b0000);
      idle(); slv_rvalid = 1'b1; slv_rid = {2'd3, 4'h9}; slv_rlast = 1'b1;
      mst_rready = 4'b0111; slv_rdata = 32'hCAFE0003;
      step(); chk("hold_rdy", 64'(s_rready), 64'd0);
      step(); chk("hold_rvalid", 64'(s_rvalid), 64'b1000);

      // reset while locked with nonzero counts
      do_reset();
      idle(); set_ar(0, 4'h1, 32'h10); slv_arready = 1'b1; step();
      idle(); set_ar(1, 4'h2, 32'h20); step(); step();
      rst_n = 1'b0; idle(); step();
      chk("mid_rst_arvalid", 64'(s_arvalid), 64'd0);
      rst_n = 1'b1;
      set_ar(0, 4'h1, 32'h10); set_ar(1, 4'h2, 32'h20); slv_arready = 1'b1;
      step(); chk("mid_rst_gnt", 64'(s_arid[IW +: XW]), 64'd0);
      idle(); set_ar(0, 4'h1, 32'h10); slv_arready = 1'b1;
      step(); chk("mid_rst_ost", 64'(s_arready), 64'b0001);

      // randomized traffic with an in-order slave
      do_reset();
      idle(); pend = '0; rv = 0; beat = 0; q.delete();
      for (int c = 0; c < 800; c++) begin
         if (c == 400) begin
            do_reset();
            idle(); pend = '0; rv = 0; beat = 0; q.delete();
            continue;
         end
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1; p_id[i] = IW'($urandom); p_addr[i] = $urandom;
               p_len[i] = LW'($urandom_range(0, 3)); p_size[i] = SW'($urandom);
               p_burst[i] = BW'($urandom);
            end
            mst_arvalid[i] = pend[i];
            mst_arid[i*IW +: IW] = p_id[i];
            mst_araddr[i*AW +: AW] = p_addr[i];
            mst_arlen[i*LW +: LW] = p_len[i];
            mst_arsize[i*SW +: SW] = p_size[i];
            mst_arburst[i*BW +: BW] = p_burst[i];
         end
         mst_rready  = N'($urandom);
         slv_arready = ($urandom_range(0, 9) < 7);
         if (!rv && q.size() > 0 && $urandom_range(0, 3) != 0) begin
            rv = 1; slv_rid = q[0].id; slv_rlast = (beat == q[0].len);
            slv_rdata = $urandom; slv_rresp = RW'($urandom);
         end
         slv_rvalid = rv;
         step();
         for (int i = 0; i < N; i++) if (mst_arvalid[i] && s_arready[i]) pend[i] = 1'b0;
         if (s_arvalid && slv_arready) q.push_back('{id: s_arid, len: int'(s_arlen)});
         if (rv && s_rready) begin
            rv = 0;
            if (slv_rlast) begin
               if (q.size() > 0) void'(q.pop_front());
               beat = 0;
            end else begin
               beat++;
            end
         end
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/easyaxi_rd_arb.md
Name: easyaxi_rd_arb

Overview:
- Parametrised N-master to 1-slave AXI read-channel interconnect. It generalises the point-to-point master/slave AR/R link to MST_NUM masters.
- AR: round-robin arbitration with grant lock until handshake. Slave-side ID is {master index, master ID}.
- R: routed back to the master selected by the upper rid bits.
- Per-master outstanding-burst limiting.
- Sits between EASYAXI_MST instances and one EASYAXI_SLV in the top level.

Parameters:
- MST_NUM, 4, number of masters (>=2); IDX_W = clog2(MST_NUM)
- ID_W, 4, master-side ID width
- ADDR_W, 32, address width
- DATA_W, 32, data width
- LEN_W, 8, arlen width
- SIZE_W, 3, arsize width
- BURST_W, 2, arburst width
- RESP_W, 2, rresp width
- MAX_OST, 2, max outstanding read bursts per master (>=1); CNT_W = clog2(MAX_OST+1)

Ports:
Clock and reset:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset

Master side. Vectors are flattened; master i occupies slice [i*W +: W].
- mst_arvalid  in  MST_NUM  AR valid per master
- mst_arready  out  MST_NUM  AR ready per master
- mst_arid  in  MST_NUM*ID_W  AR ID
- mst_araddr  in  MST_NUM*ADDR_W  AR address
- mst_arlen  in  MST_NUM*LEN_W  AR length
- mst_arsize  in  MST_NUM*SIZE_W  AR size
- mst_arburst  in  MST_NUM*BURST_W  AR burst type
- mst_rvalid  out  MST_NUM  R valid per master
- mst_rready  in  MST_NUM  R ready per master
- mst_rid  out  MST_NUM*ID_W  R ID
- mst_rdata  out  MST_NUM*DATA_W  R data
- mst_rresp  out  MST_NUM*RESP_W  R response
- mst_rlast  out  MST_NUM  R last

Slave side:
- slv_arvalid  out  1  AR valid to slave
- slv_arready  in  1  AR ready from slave
- slv_arid  out  IDX_W+ID_W  {grant index, master arid}
- slv_araddr/arlen/arsize/arburst  out  ADDR_W/LEN_W/SIZE_W/BURST_W  AR payload of the granted master
- slv_rvalid  in  1  R valid from slave
- slv_rready  out  1  R ready to slave
- slv_rid  in  IDX_W+ID_W  R ID from slave
- slv_rdata  in  DATA_W  R data
- slv_rresp  in  RESP_W  R response
- slv_rlast  in  1  R last

Behaviour:
Reset:
- rst_n low: rr_ptr=0, lock=0, lock_idx=0, all ost_cnt=0.
- Outputs are combinational from state and inputs. With all inputs idle, every valid/ready output is 0.

Eligibility:
- req[i] = mst_arvalid[i] & (ost_cnt[i] < MAX_OST).
- A master at its limit is not eligible and sees mst_arready[i]=0.

AR arbitration, unlocked:
- Winner is the first i with req[i], searching from rr_ptr upward with wrap-around.
- Winner payload is driven to slave the same cycle: zero-latency combinational path.
- slv_arvalid = |req.
- mst_arready[winner] = slv_arready; all other mst_arready = 0.

AR arbitration, locked:
- slv_arvalid=1 with the lock_idx payload; other requests are ignored.
- Preserves AXI valid-stability across slave backpressure.

Lock and pointer transitions:
- Valid & !slv_arready while unlocked: lock=1, lock_idx=winner.
- Handshake (slv_arvalid & slv_arready): lock=0, rr_ptr=(granted+1) mod MST_NUM.
- No request: state unchanged.

R routing:
- sel = slv_rid[ID_W +: IDX_W].
- If sel < MST_NUM: mst_rvalid[sel]=slv_rvalid; slv_rready=mst_rready[sel]; mst_rid/rdata/rresp/rlast slices of sel carry slv_rid[ID_W-1:0] and slave payload.
- All other mst_rvalid are 0; other payload slices are don't-care (driven with slave payload).
- sel >= MST_NUM (non-power-of-2 MST_NUM): slv_rready=1, beat discarded, no master sees it.

Outstanding counters:
- ost_cnt[i]++ on AR handshake for i.
- ost_cnt[i]-- on R handshake with rlast for i.
- Both in the same cycle: unchanged.
- No overflow by construction (eligibility gate). Decrement at 0 cannot occur with a compliant slave; the counter saturates at 0.
- AR and R are independent: AR for master A and R to master B proceed in the same cycle.

Reset mid-operation:
- All state is cleared immediately; in-flight bursts are abandoned.

Test Plan:
1. Single master: m1 arvalid, arid=4'h3, araddr=0x100, slave ready → slv_arid=6'h13 same cycle, m1 arready=1; R beats with rid=6'h13, rlast on 4th → only m1 rvalid, m1 rid=4'h3, ost_cnt[1] 1→0.
2. Round-robin: m0..m3 request continuously, slave always ready → grant order 0,1,2,3,0; rr_ptr wraps 3→0.
3. Backpressure lock: m2 granted, slv_arready=0 for 3 cycles while m0 also requests → slv_arid/araddr stay on m2 payload, m0 arready=0; on ready, m2 handshakes, next grant is m3 if it requests, else m0.
4. Outstanding limit (MAX_OST=2): m0 issues 2 ARs, no R → third request gives m0 arready=0, and m1 is granted instead; after one rlast to m0, m0 is eligible again.
5. Simultaneous events: m0 AR handshake and m0 rlast handshake in the same cycle → ost_cnt[0] unchanged; R beat for m3 with rready=0 → slv_rready=0 and beat held.
6. Reset mid-burst: assert rst_n low while locked and counts nonzero → lock=0, rr_ptr=0, counts 0, slv_arvalid=0 with masters idle.
